vehicle_request: RTL and testbench
==================================

# vehicle_request

Vehicle-detector front end that sits on the request side of the traffic-light controller. It conditions the raw inductive-loop input, counts waiting vehicles, and drives the controller's `sensor` request until a green phase is observed. It also watches the controller's lamp outputs (`red`, `yellow`, `green`) to retire served requests and flag illegal lamp behaviour.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples needed before the clean loop level changes; legal range is 1 or more.
- `CNT_W`, default 8: width of the pending-vehicle counter.

Ports:
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `loop_raw` input 1: raw loop detector, asynchronous, may bounce.
- `red` input 1: controller red lamp.
- `yellow` input 1: controller yellow lamp.
- `green` input 1: controller green lamp.
- `sensor` output 1: registered request to the controller.
- `pending_count` output CNT_W: vehicles waiting; saturating.
- `served` output 1: one-cycle pulse when a request is retired by green.
- `error` output 1: sticky lamp-protocol violation flag.

## Operation

- Synchronizer: `loop_raw` passes through two flops, s1 then s2.
- Debounce:
  - Register `loop_clean`, plus a counter of width clog2(DEBOUNCE_CYCLES)+1.
  - Each edge where s2 differs from `loop_clean`, the counter increments.
  - When the count reaches DEBOUNCE_CYCLES, `loop_clean` takes s2 on that edge and the counter clears.
  - Any edge where s2 equals `loop_clean` clears the counter.
- Arrival: a 0→1 update of `loop_clean` is an arrival.
  - `pending_count` increments on that same edge.
  - It saturates at 2^CNT_W−1.
- Green detection: `green_d` register; `green_rise` = `green` & ~`green_d`.
- FSM states:
  - IDLE: `sensor`=0. Moves to REQ when `pending_count` != 0.
  - REQ: `sensor`=1. On `green_rise`, moves to SERVED, clears `pending_count`, and pulses `served`.
  - SERVED: `sensor`=0, so the controller cannot re-trigger during its cycle. When red, yellow and green are all 0, moves to REQ if `pending_count` != 0, else IDLE.
- Simultaneous arrival and `green_rise`: the arrival is not served, so `pending_count` becomes 1 and not 0.
- `error` sets, and holds until `rst`, on any edge where either:
  - more than one lamp is high, or
  - `green_rise` occurs while the state is IDLE or SERVED (unrequested green).
- Falling edges of `loop_clean` (vehicle departure) have no effect on the count.

## Timing

- Reset values: `sensor`=0, `pending_count`=0, `served`=0, `error`=0. Internally: s1=s2=0, `loop_clean`=0, debounce counter=0, `green_d`=0, state IDLE.
- A synchronous `rst` mid-operation discards pending vehicles and any debounce in progress. The first post-reset edge behaves as from power-up.
- Arrival latency, with `loop_raw` high and stable from just before edge k:
  - s2 is high after edge k+1.
  - `loop_clean` and `pending_count` update at edge k+1+DEBOUNCE_CYCLES.
  - `sensor` is high after edge k+2+DEBOUNCE_CYCLES.
- A pulse shorter than DEBOUNCE_CYCLES synchronized cycles is ignored.
- Service latency: on the edge where `green_rise` is seen in REQ:
  - state becomes SERVED, `pending_count` is cleared, and `sensor` is low after that edge;
  - `served` is high for exactly that one following cycle.
- `served` is never asserted outside the REQ→SERVED transition.
- SERVED exits on the first edge that samples all lamps low. Minimum dwell is one cycle.
- `pending_count` arithmetic is unsigned. Saturation takes priority over increment; clear-on-green takes priority over saturation.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4 and CNT_W=8 unless noted.
- Reset: assert `rst` for 2 cycles with `loop_raw`=1 → all outputs 0 during and one edge after reset; no arrival counted until 6 edges after release.
- Clean arrival: `loop_raw` goes 0→1 before edge 0 and is held → `pending_count`=1 after edge 5, `sensor`=1 after edge 6, `error`=0.
- Bounce rejection: `loop_raw` high for 3 cycles, low 2, high 3, then low → `pending_count` stays 0 and `sensor` stays 0 throughout.
- Service cycle:
  - Stimulus: 3 separated arrivals, then green=1 for 1 cycle, yellow for 1, red for 1, then all lamps off.
  - Response: `pending_count`=3 before green; `served` pulses once; `pending_count`=0 and `sensor`=0 after the green edge; state returns to IDLE once lamps are off.
- Simultaneous events and saturation:
  - With CNT_W=2: 5 arrivals → `pending_count`=3.
  - Then an arrival landing on the `green_rise` edge → `pending_count`=1, and `sensor` reasserts after lamps go dark.
- Protocol errors:
  - `green`+`red` high together → `error`=1 after that edge, held through further legal traffic until `rst`.
  - After reset, with no request pending, `green` pulses high → `error`=1.

Source files
------------

// File: rtl/vehicle_request.sv
// Vehicle-detector front end: conditions the loop input, counts waiting
// vehicles, requests service from the light controller and checks lamp sanity.
module vehicle_request #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             loop_raw,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  output logic             sensor,
  output logic [CNT_W-1:0] pending_count,
  output logic             served,
  output logic             error
);

  localparam int unsigned      DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_SERVED = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            s1;
  logic            s2;
  logic            loop_clean;
  logic [DB_W-1:0] db_cnt;
  logic            green_d;

  logic            db_fire_c;
  logic            arrival_c;
  logic            green_rise_c;
  logic            multi_lamp_c;
  logic            serve_c;
  logic            lamps_dark_c;

  // Event decode shared by the counter, FSM and error logic
  always_comb begin
    db_fire_c    = (s2 != loop_clean) && (db_cnt == DB_LAST);
    arrival_c    = db_fire_c && s2;
    green_rise_c = green & ~green_d;
    multi_lamp_c = (red & yellow) | (red & green) | (yellow & green);
    lamps_dark_c = ~(red | yellow | green);
    serve_c      = (state_q == S_REQ) && green_rise_c;
  end

  // Two-flop synchronizer followed by a stable-run debouncer
  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      loop_clean <= 1'b0;
      db_cnt     <= '0;
    end else begin
      s1 <= loop_raw;
      s2 <= s1;
      if (s2 == loop_clean) begin
        db_cnt <= '0;
      end else if (db_fire_c) begin
        loop_clean <= s2;
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Saturating vehicle counter; a green service clears it, but an arrival
  // on the same edge was not served and is kept
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_count <= '0;
    end else if (serve_c) begin
      pending_count <= arrival_c ? CNT_W'(1) : '0;
    end else if (arrival_c && (pending_count != CNT_MAX)) begin
      pending_count <= pending_count + CNT_W'(1);
    end
  end

  // Next-state logic for the request handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pending_count != '0) state_d = S_REQ;
      S_REQ:    if (green_rise_c) state_d = S_SERVED;
      S_SERVED: if (lamps_dark_c) state_d = (pending_count != '0) ? S_REQ : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register, registered outputs and sticky lamp-protocol flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sensor  <= 1'b0;
      served  <= 1'b0;
      error   <= 1'b0;
      green_d <= 1'b0;
    end else begin
      state_q <= state_d;
      sensor  <= (state_d == S_REQ);
      served  <= serve_c;
      green_d <= green;
      if (multi_lamp_c || (green_rise_c && (state_q != S_REQ))) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vehicle_request.sv
// Self-checking bench for vehicle_request: directed table, hand sequences and
// random traffic against a behavioural model (two counter widths in parallel).
module tb_vehicle_request;

  localparam int DB      = 4;
  localparam int P_IDLE  = 0;
  localparam int P_REQ   = 1;
  localparam int P_SERV  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, loop_raw, red, yellow, green;
  logic       sensor8, served8, error8;
  logic [7:0] pend8;
  logic       sensor2, served2, error2;
  logic [1:0] pend2;

  vehicle_request #(.DEBOUNCE_CYCLES(DB), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .loop_raw(loop_raw), .red(red), .yellow(yellow),
    .green(green), .sensor(sensor8), .pending_count(pend8), .served(served8),
    .error(error8)
  );

  vehicle_request #(.DEBOUNCE_CYCLES(DB), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .loop_raw(loop_raw), .red(red), .yellow(yellow),
    .green(green), .sensor(sensor2), .pending_count(pend2), .served(served2),
    .error(error2)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: unbounded vehicle tally, clipped per counter width
  bit raw_hist[$];
  int m_clean, m_run, m_wait, m_phase, m_prev_g;
  bit m_err, m_served;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clip(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step();
    int s2v;
    int lamps;
    bit arrival;
    bit grise;
    if (rst) begin
      raw_hist.delete();
      m_clean = 0; m_run = 0; m_wait = 0; m_phase = P_IDLE;
      m_prev_g = 0; m_err = 0; m_served = 0;
    end else begin
      // loop_raw reaches the debouncer two edges after it is sampled
      s2v = (raw_hist.size() >= 2) ? int'(raw_hist[raw_hist.size()-2]) : 0;
      raw_hist.push_back(loop_raw);
      while (raw_hist.size() > 2) void'(raw_hist.pop_front());
      arrival = 1'b0;
      if (s2v != m_clean) begin
        m_run++;
        if (m_run >= DB) begin
          m_clean = s2v;
          m_run   = 0;
          arrival = (s2v == 1);
        end
      end else begin
        m_run = 0;
      end
      grise    = green && (m_prev_g == 0);
      m_prev_g = int'(green);
      lamps    = int'(red) + int'(yellow) + int'(green);
      if (lamps > 1 || (grise && m_phase != P_REQ)) m_err = 1'b1;
      m_served = 1'b0;
      case (m_phase)
        P_IDLE: if (m_wait != 0) m_phase = P_REQ;
        P_REQ: if (grise) begin
          m_phase  = P_SERV;
          m_served = 1'b1;
          m_wait   = 0;
        end
        default: if (lamps == 0) m_phase = (m_wait != 0) ? P_REQ : P_IDLE;
      endcase
      if (arrival) m_wait++;
    end
  endtask

  task automatic model_compare();
    int exp_sensor;
    exp_sensor = (m_phase == P_REQ) ? 1 : 0;
    chk("m_sensor8", int'(sensor8), exp_sensor);
    chk("m_pend8",   int'(pend8),   clip(m_wait, 255));
    chk("m_served8", int'(served8), int'(m_served));
    chk("m_error8",  int'(error8),  int'(m_err));
    chk("m_sensor2", int'(sensor2), exp_sensor);
    chk("m_pend2",   int'(pend2),   clip(m_wait, 3));
    chk("m_served2", int'(served2), int'(m_served));
    chk("m_error2",  int'(error2),  int'(m_err));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_compare();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic [4:0] stim;   // rst, loop_raw, red, yellow, green
    logic       sensor;
    logic [7:0] pend;
    logic       served;
    logic       err;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] s, input logic se,
                              input logic [7:0] p, input logic sv,
                              input logic e);
    vec_t v;
    v.stim = s; v.sensor = se; v.pend = p; v.served = sv; v.err = e;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    rst = 1'b1; loop_raw = 1'b1; red = 1'b0; yellow = 1'b0; green = 1'b0;

    // Reset with loop high, clean arrival, then a full lamp cycle
    tbl[0]  = mk(5'b11000, 1'b0, 8'd0, 1'b0, 1'b0);
    tbl[1]  = mk(5'b11000, 1'b0, 8'd0, 1'b0, 1'b0);
    tbl[2]  = mk(5'b01000, 1'b0, 8'd0, 1'b0, 1'b0);
    tbl[3]  = mk(5'b01000, 1'b0, 8'd0, 1'b0, 1'b0);
    tbl[4]  = mk(5'b01000, 1'b0, 8'd0, 1'b0, 1'b0);
    tbl[5]  = mk(5'b01000, 1'b0, 8'd0, 1'b0, 1'b0);
    tbl[6]  = mk(5'b01000, 1'b0, 8'd0, 1'b0, 1'b0);
    tbl[7]  = mk(5'b01000, 1'b0, 8'd1, 1'b0, 1'b0);
    tbl[8]  = mk(5'b01000, 1'b1, 8'd1, 1'b0, 1'b0);
    tbl[9]  = mk(5'b01000, 1'b1, 8'd1, 1'b0, 1'b0);
    tbl[10] = mk(5'b01001, 1'b0, 8'd0, 1'b1, 1'b0);
    tbl[11] = mk(5'b01010, 1'b0, 8'd0, 1'b0, 1'b0);
    tbl[12] = mk(5'b01100, 1'b0, 8'd0, 1'b0, 1'b0);
    tbl[13] = mk(5'b01000, 1'b0, 8'd0, 1'b0, 1'b0);
    tbl[14] = mk(5'b00000, 1'b0, 8'd0, 1'b0, 1'b0);

    for (int i = 0; i < 15; i++) begin
      {rst, loop_raw, red, yellow, green} = tbl[i].stim;
      tick();
      chk($sformatf("tbl%0d_sensor", i), int'(sensor8), int'(tbl[i].sensor));
      chk($sformatf("tbl%0d_pend",   i), int'(pend8),   int'(tbl[i].pend));
      chk($sformatf("tbl%0d_served", i), int'(served8), int'(tbl[i].served));
      chk($sformatf("tbl%0d_error",  i), int'(error8),  int'(tbl[i].err));
    end

    // Bounce rejection: 3 high, 2 low, 3 high never reaches the threshold
    ticks(8);
    loop_raw = 1'b1; for (int i = 0; i < 3; i++) begin tick(); chk("bounce_pend", int'(pend8), 0); end
    loop_raw = 1'b0; for (int i = 0; i < 2; i++) begin tick(); chk("bounce_pend", int'(pend8), 0); end
    loop_raw = 1'b1; for (int i = 0; i < 3; i++) begin tick(); chk("bounce_pend", int'(pend8), 0); end
    loop_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("bounce_pend", int'(pend8), 0);
      chk("bounce_sensor", int'(sensor8), 0);
    end

    // A pulse of exactly the debounce length is accepted
    loop_raw = 1'b1; ticks(4);
    loop_raw = 1'b0; ticks(10);
    chk("exact_pulse_pend", int'(pend8), 1);
    chk("exact_pulse_sensor", int'(sensor8), 1);

    // Saturation with a 2-bit counter
    rst = 1'b1; ticks(2); rst = 1'b0;
    for (int a = 0; a < 5; a++) begin
      loop_raw = 1'b1; ticks(8);
      loop_raw = 1'b0; ticks(8);
      chk("sat_pend8", int'(pend8), a + 1);
      chk("sat_pend2", int'(pend2), clip(a + 1, 3));
    end

    // Arrival on the green_rise edge survives the clear
    loop_raw = 1'b1; ticks(5);
    green = 1'b1; tick();
    chk("simul_pend8", int'(pend8), 1);
    chk("simul_pend2", int'(pend2), 1);
    chk("simul_served", int'(served8), 1);
    chk("simul_sensor", int'(sensor8), 0);
    green = 1'b0; tick();
    chk("simul_reassert8", int'(sensor8), 1);
    chk("simul_reassert2", int'(sensor2), 1);
    chk("simul_error", int'(error8), 0);
    loop_raw = 1'b0; ticks(8);

    // Two lamps at once is sticky until reset
    rst = 1'b1; ticks(2); rst = 1'b0;
    red = 1'b1; green = 1'b1; tick();
    chk("dual_lamp_error", int'(error8), 1);
    red = 1'b0; green = 1'b0;
    loop_raw = 1'b1; ticks(8); loop_raw = 1'b0; ticks(8);
    green = 1'b1; tick(); chk("legal_served", int'(served8), 1);
    green = 1'b0; yellow = 1'b1; tick();
    yellow = 1'b0; red = 1'b1; tick();
    red = 1'b0; tick();
    chk("error_held", int'(error8), 1);
    rst = 1'b1; tick();
    chk("error_cleared", int'(error8), 0);

    // Unrequested green from IDLE
    rst = 1'b0; green = 1'b1; tick();
    chk("unreq_green_error", int'(error8), 1);
    chk("unreq_green_served", int'(served8), 0);
    green = 1'b0; tick();

    // Random traffic against the model
    begin
      int raw_hold = 0;
      int lamp_hold = 0;
      int sel;
      rst = 1'b1; ticks(2); rst = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        if (raw_hold == 0) begin
          loop_raw = ~loop_raw;
          raw_hold = int'($urandom_range(1, 9));
        end
        raw_hold--;
        if (lamp_hold == 0) begin
          sel = int'($urandom_range(0, 5));
          {red, yellow, green} = (sel == 1) ? 3'b100 :
                                 (sel == 2) ? 3'b010 :
                                 (sel == 3) ? 3'b001 : 3'b000;
          if ($urandom_range(0, 31) == 0) {red, yellow, green} = 3'b101;
          lamp_hold = int'($urandom_range(1, 12));
        end
        lamp_hold--;
        rst = ($urandom_range(0, 399) == 0);
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
